// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sobel_pkg
// Brief   : Shared kernel-mode encodings and accumulator width helper.
// Revision: 1.0
// ============================================================================
package sobel_pkg;

    typedef enum logic [1:0] {
        MODE_SOBEL   = 2'd0,
        MODE_PREWITT = 2'd1,
        MODE_GAUSS   = 2'd2,
        MODE_PASS    = 2'd3
    } mode_e;

    localparam int ACC_GUARD = 4;

    // Accumulator width: ACC_W = DW + 4 holds a 16x-weighted pixel sum.
    function automatic int acc_width(input int dw);
        return dw + ACC_GUARD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
// Module  : line_buffer
// Brief   : Two cascaded DEPTH-deep delay lines, taps at DEPTH and 2*DEPTH.
// Revision: 1.0
// ============================================================================
module line_buffer #(
    parameter int DW    = 8,
    parameter int DEPTH = 160
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_en,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_tap1,
    output logic [DW-1:0] o_tap2
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0]      r_mem1 [0:DEPTH-1];
    logic [DW-1:0]      r_mem2 [0:DEPTH-1];
    logic [c_ptr_w-1:0] r_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == c_ptr_w'(DEPTH-1)) ? '0 : r_ptr + 1'b1;
        end
    end

    // Read-before-write at the same slot yields exactly DEPTH accepts of delay.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem1[r_ptr] <= i_data;
            r_mem2[r_ptr] <= r_mem1[r_ptr];
        end
    end

    assign o_tap1 = r_mem1[r_ptr];
    assign o_tap2 = r_mem2[r_ptr];

endmodule
`default_nettype wire

// File: rtl/sobel_filter_core.sv
`default_nettype none
// ============================================================================
// Module  : sobel_filter_core
// Brief   : 3x3 Sobel/Prewitt/Gaussian/pass filter, 3-clock pipeline.
// Revision: 1.0
// ============================================================================
module sobel_filter_core
    import sobel_pkg::*;
#(
    parameter int DW       = 8,
    parameter int HOR_PIC  = 160,
    parameter int VERT_PIC = 160
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] data_in,
    input  logic          data_ready,
    input  logic          frame_start,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] threshold,
    output logic [DW-1:0] data_out,
    output logic          data_bin,
    output logic          data_valid,
    output logic          data_eol,
    output logic          data_eof
);

    localparam int            ACC_W         = acc_width(DW);
    localparam int            c_col_w       = $clog2(HOR_PIC);
    localparam int            c_row_w       = $clog2(VERT_PIC);
    localparam int            c_gauss_shift = 4;
    localparam logic [DW-1:0] c_pix_max     = '1;

    function automatic logic [ACC_W-1:0] ext(input logic [DW-1:0] v);
        return ACC_W'(v);
    endfunction

    // ---------------- stage 0: position, line buffers, window ----------------
    logic [c_col_w-1:0] r_col, w_col;
    logic [c_row_w-1:0] r_row, w_row;
    logic               w_col_last, w_row_last, w_interior;
    logic [DW-1:0]      w_tap1, w_tap2;
    logic [DW-1:0]      r_win [0:2][0:2];
    mode_e              r_mode_q;
    logic [DW-1:0]      r_thr_q;
    logic               r_v0, r_eol0, r_eof0;

    assign w_col      = frame_start ? '0 : r_col;
    assign w_row      = frame_start ? '0 : r_row;
    assign w_col_last = (w_col == c_col_w'(HOR_PIC-1));
    assign w_row_last = (w_row == c_row_w'(VERT_PIC-1));
    assign w_interior = (w_col >= c_col_w'(2)) && (w_row >= c_row_w'(2));

    line_buffer #(.DW(DW), .DEPTH(HOR_PIC)) u_line_buffer (
        .clk    (clk),
        .rstn   (rstn),
        .i_en   (data_ready),
        .i_data (data_in),
        .o_tap1 (w_tap1),
        .o_tap2 (w_tap2)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_col    <= '0;
            r_row    <= '0;
            r_mode_q <= MODE_SOBEL;
            r_thr_q  <= '1;
            r_v0     <= 1'b0;
            r_eol0   <= 1'b0;
            r_eof0   <= 1'b0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    r_win[i][j] <= '0;
        end else begin
            r_v0   <= data_ready && w_interior;
            r_eol0 <= w_col_last;
            r_eof0 <= w_col_last && w_row_last;
            if (data_ready) begin
                r_col <= w_col_last ? '0 : w_col + 1'b1;
                if (w_col_last)
                    r_row <= w_row_last ? '0 : w_row + 1'b1;
                else
                    r_row <= w_row;
                if (w_col == '0 && w_row == '0) begin
                    r_mode_q <= mode_e'(mode);
                    r_thr_q  <= threshold;
                end
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= w_tap2;
                r_win[1][2] <= w_tap1;
                r_win[2][2] <= data_in;
            end
        end
    end

    // ---------------- stage 1: weighted edge sums ----------------
    logic             w_dbl;
    logic [ACC_W-1:0] w_l, w_r, w_t, w_b, w_ga, w_gb;

    assign w_dbl = (r_mode_q == MODE_SOBEL);

    always_comb begin
        w_l  = ext(r_win[0][0]) + ext(r_win[2][0]) + (w_dbl ? (ext(r_win[1][0]) << 1) : ext(r_win[1][0]));
        w_r  = ext(r_win[0][2]) + ext(r_win[2][2]) + (w_dbl ? (ext(r_win[1][2]) << 1) : ext(r_win[1][2]));
        w_t  = ext(r_win[0][0]) + ext(r_win[0][2]) + (w_dbl ? (ext(r_win[0][1]) << 1) : ext(r_win[0][1]));
        w_b  = ext(r_win[2][0]) + ext(r_win[2][2]) + (w_dbl ? (ext(r_win[2][1]) << 1) : ext(r_win[2][1]));
        w_ga = ext(r_win[0][0]) + ext(r_win[0][2]) + ext(r_win[2][0]) + ext(r_win[2][2]);
        w_gb = ext(r_win[0][1]) + ext(r_win[1][0]) + ext(r_win[1][2]) + ext(r_win[2][1]);
    end

    logic [ACC_W-1:0] r_l1, r_r1, r_t1, r_b1, r_ga1, r_gb1;
    logic [DW-1:0]    r_c1, r_thr1;
    mode_e            r_mode1;
    logic             r_v1, r_eol1, r_eof1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {r_l1, r_r1, r_t1, r_b1, r_ga1, r_gb1} <= '0;
            r_c1    <= '0;
            r_thr1  <= '0;
            r_mode1 <= MODE_SOBEL;
            r_v1    <= 1'b0;
            r_eol1  <= 1'b0;
            r_eof1  <= 1'b0;
        end else begin
            r_l1    <= w_l;
            r_r1    <= w_r;
            r_t1    <= w_t;
            r_b1    <= w_b;
            r_ga1   <= w_ga;
            r_gb1   <= w_gb;
            r_c1    <= r_win[1][1];
            r_thr1  <= r_thr_q;
            r_mode1 <= r_mode_q;
            r_v1    <= r_v0;
            r_eol1  <= r_eol0;
            r_eof1  <= r_eof0;
        end
    end

    // ---------------- stage 2: absolute differences / Gaussian sum ----------------
    logic [ACC_W-1:0] r_gx2, r_gy2, r_gs2;
    logic [DW-1:0]    r_c2, r_thr2;
    mode_e            r_mode2;
    logic             r_v2, r_eol2, r_eof2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            {r_gx2, r_gy2, r_gs2} <= '0;
            r_c2    <= '0;
            r_thr2  <= '0;
            r_mode2 <= MODE_SOBEL;
            r_v2    <= 1'b0;
            r_eol2  <= 1'b0;
            r_eof2  <= 1'b0;
        end else begin
            r_gx2   <= (r_l1 > r_r1) ? (r_l1 - r_r1) : (r_r1 - r_l1);
            r_gy2   <= (r_t1 > r_b1) ? (r_t1 - r_b1) : (r_b1 - r_t1);
            r_gs2   <= r_ga1 + (r_gb1 << 1) + (ext(r_c1) << 2);
            r_c2    <= r_c1;
            r_thr2  <= r_thr1;
            r_mode2 <= r_mode1;
            r_v2    <= r_v1;
            r_eol2  <= r_eol1;
            r_eof2  <= r_eof1;
        end
    end

    // ---------------- stage 3: saturate / shift / select, registered outputs ----------------
    logic [ACC_W-1:0] w_mag;
    logic [DW-1:0]    w_res;

    assign w_mag = r_gx2 + r_gy2;

    always_comb begin
        w_res = r_c2;
        case (r_mode2)
            MODE_SOBEL, MODE_PREWITT: w_res = (w_mag > ext(c_pix_max)) ? c_pix_max : w_mag[DW-1:0];
            MODE_GAUSS:               w_res = r_gs2[c_gauss_shift +: DW];
            default:                  w_res = r_c2;
        endcase
    end

    logic [DW-1:0] r_data_out;
    logic          r_data_bin, r_data_valid, r_data_eol, r_data_eof;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data_out   <= '0;
            r_data_bin   <= 1'b0;
            r_data_valid <= 1'b0;
            r_data_eol   <= 1'b0;
            r_data_eof   <= 1'b0;
        end else begin
            r_data_out   <= w_res;
            r_data_bin   <= (w_res > r_thr2);
            r_data_valid <= r_v2;
            r_data_eol   <= r_eol2;
            r_data_eof   <= r_eof2;
        end
    end

    assign data_out   = r_data_out;
    assign data_bin   = r_data_bin;
    assign data_valid = r_data_valid;
    assign data_eol   = r_data_eol;
    assign data_eof   = r_data_eof;

endmodule
`default_nettype wire

// File: doc/sobel_filter_core.md
# sobel_filter_core

Parametrised 3x3 neighbourhood filter: the next generation of the binary Sobel edge detector in the camera-to-LCD pipeline. It takes a raster stream of grey pixels with a per-pixel strobe and produces, for every interior pixel, a saturated gradient or smoothed magnitude plus a thresholded edge bit. Compared with the earlier detector it adds configurable pixel width and image size, a run-time kernel mode and threshold latched per frame, frame resynchronisation, and row/frame end markers. It sits between the greyscale converter and the display frame buffer.

## Interface
- `DW`, 8: pixel width in bits (4..12)
- `HOR_PIC`, 160: image width in pixels (≥3)
- `VERT_PIC`, 160: image height in lines (≥3)
- `clk` input 1: pixel clock
- `rstn` input 1: reset, asynchronous, active-low
- `data_in` input DW: input pixel, raster order
- `data_ready` input 1: `data_in` is valid this cycle; the pixel is accepted at this clock edge
- `frame_start` input 1: qualified by `data_ready`; marks the current pixel as (row 0, col 0)
- `mode` input 2: 0 Sobel, 1 Prewitt, 2 Gaussian blur, 3 pass-through
- `threshold` input DW: edge threshold
- `data_out` output DW: filtered magnitude
- `data_bin` output 1: `data_out > thr_q`
- `data_valid` output 1: `data_out` and `data_bin` hold an interior result
- `data_eol` output 1: last valid pixel of a row
- `data_eof` output 1: last valid pixel of a frame

## Operation
- Column/row counters advance only on accepted pixels and wrap at `HOR_PIC-1` / `VERT_PIC-1`. Frame wrap returns both counters to 0.
- `frame_start & data_ready` forces the accepted pixel to (0,0), overriding the counter state. This is the resync path after a dropped or partial frame.
- `mode` and `threshold` are sampled into `mode_q`/`thr_q` only when the accepted pixel is at (0,0). Changes during a frame take effect on the next frame.
- Two line buffers of depth `HOR_PIC` supply rows r-2 and r-1. They shift only on accept. A 3x3 window register also shifts only on accept.
- Valid window: the accepted pixel is at col ≥2 and row ≥2. The window centre is then (row-1, col-1). Each frame yields (HOR_PIC-2)·(VERT_PIC-2) results, and no border pixels are emitted.
- Sobel: Gx = |L−R|, Gy = |T−B|, with column/row weights 1,2,1. Prewitt uses the same form with weights 1,1,1. Magnitude is Gx+Gy, computed at DW+4 bits and saturated to 2^DW−1.
- Gaussian: kernel 1 2 1 / 2 4 2 / 1 2 1, sum at DW+4 bits, then `>>4` (truncate).
- Pass-through: window centre pixel.
- `data_eol` asserts with the result for input col `HOR_PIC-1`. `data_eof` asserts additionally when the input row is `VERT_PIC-1`.
- Reset clears counters, the window, pipeline valids, `mode_q` (to 0) and `thr_q` (to all-ones). Line buffer contents need not be cleared, because no valid output depends on them before two full lines have arrived.

## Timing
- Reset values: all outputs 0.
- Pipeline stages advance every clock, independent of `data_ready`. The stage valids carry the accept-and-interior flag.
- Latency is 3 clocks. For a pixel accepted at edge k:
  - edge k+1: partial sums
  - edge k+2: absolute differences / Gaussian sum
  - edge k+3: saturate/shift, registered outputs
- `data_valid` is high for exactly one cycle per result. Gaps in `data_ready` produce matching gaps at the output and never cause duplicates.
- `data_bin`, `data_eol` and `data_eof` are registered with `data_out` and are only meaningful while `data_valid` is high.
- A `frame_start` mid-frame takes effect at the same accepting edge. Results already in the pipeline still drain.
- Asserting `rstn` low mid-frame kills in-flight results immediately. The first valid after reset requires two complete lines.

## Structure
- Shared package `sobel_pkg`:
  - mode encodings `MODE_SOBEL`, `MODE_PREWITT`, `MODE_GAUSS`, `MODE_PASS`
  - width helper constant `ACC_W = DW+4`
- Sub-module `line_buffer`:
  - parameters `DW` and `DEPTH`, clock enable
  - two taps (delay DEPTH and 2·DEPTH), inferring block RAM or shift register
  - replaces the vendor shift-register IP

## Test plan
1. DW=8, HOR_PIC=VERT_PIC=8, flat image of 100, mode 0 → exactly 36 valids, `data_out`=0, `data_bin`=0, with one `data_eol` per 6 results and `data_eof` on the 36th.
2. Vertical step (cols 0–3 = 0, cols 4–7 = 60), threshold 200:
   - mode 0: centres at col 3 and col 4 give 240, `data_bin`=1; others give 0.
   - mode 1: the same centres give 180, `data_bin`=0.
3. Vertical step 0→255 in mode 0 → the step columns saturate to 255. Flat image of 100 in mode 2 → 100. Mode 3 → `data_out` equals the centre pixel.
4. Same frame as test 2 with `data_ready` randomly 50% duty → an identical result sequence with 3-cycle latency from each accepting edge.
5. Switch `mode` 0→1 at row 4 → the rest of that frame stays Sobel; the next frame is Prewitt.
6. Pull `rstn` low at row 3 → outputs 0 immediately. Then inject a `frame_start` at an arbitrary counter state → the next frame produces 36 correctly positioned results.
